// File: rtl/pipeline_hazard_unit_if.sv
// Hazard unit bundle: decode-side request fields and hazard-unit control results.
// master = decode/pipeline side (drives id_*, flush_req, stall_ext); slave = hazard unit.
interface pipeline_hazard_unit_if #(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_STAGES = 3
);
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_src1_used;
  logic                  id_src2_used;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush_req;
  logic                  stall_ext;
  logic                  stall;
  logic                  bubble;
  logic                  flush_fd;
  logic [SEL_W-1:0]      fwd_sel1;
  logic [SEL_W-1:0]      fwd_sel2;
  logic [15:0]           stall_cnt;
  logic [15:0]           flush_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
    output id_dst, id_reg_write, id_mem_read, flush_req, stall_ext,
    input  stall, bubble, flush_fd, fwd_sel1, fwd_sel2,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
    input  id_dst, id_reg_write, id_mem_read, flush_req, stall_ext,
    output stall, bubble, flush_fd, fwd_sel1, fwd_sel2,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller: tracks writers in NUM_STAGES post-decode stages,
// drives fwd selects, load-use stall/bubble and flush. Ports: clk, reset_n, hz (slave).
// Optional HAZARD_STATS_EN builds saturating 16-bit stall/flush counters.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pipeline_hazard_unit_if.slave hz
);
  localparam int N     = NUM_STAGES;
  localparam int SEL_W = $clog2(NUM_STAGES + 1);

  logic [N:1]            v_q, v_d;
  logic [N:1]            wr_q, wr_d;
  logic [N:1]            ld_q, ld_d;
  logic [REG_ADDR_W-1:0] dst_q [1:N];
  logic [REG_ADDR_W-1:0] dst_d [1:N];

  logic             m1, m2, lu;
  logic [SEL_W-1:0] sel1, sel2;

  assign m1 = hz.id_src1_used && (dst_q[1] == hz.id_src1);
  assign m2 = hz.id_src2_used && (dst_q[1] == hz.id_src2);
  assign lu = hz.id_valid && v_q[1] && ld_q[1] && wr_q[1] && (m1 || m2);

  // Scan from the far end so the nearest stage overwrites older hits.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int k = N; k >= 1; k--) begin
      if (hz.id_valid && v_q[k] && wr_q[k]) begin
        if (hz.id_src1_used && dst_q[k] == hz.id_src1)
          sel1 = SEL_W'(k);
        if (hz.id_src2_used && dst_q[k] == hz.id_src2)
          sel2 = SEL_W'(k);
      end
    end
  end

  // Outputs forced low while reset is held, even for the pass-through terms.
  assign hz.stall    = reset_n && (lu || hz.stall_ext);
  assign hz.bubble   = reset_n && lu && !hz.stall_ext && !hz.flush_req;
  assign hz.flush_fd = reset_n && hz.flush_req && !hz.stall_ext;
  assign hz.fwd_sel1 = reset_n ? sel1 : '0;
  assign hz.fwd_sel2 = reset_n ? sel2 : '0;

  always_comb begin
    v_d   = v_q;
    wr_d  = wr_q;
    ld_d  = ld_q;
    dst_d = dst_q;
    if (!hz.stall_ext) begin
      for (int k = N; k >= 2; k--) begin
        v_d[k]   = v_q[k-1];
        wr_d[k]  = wr_q[k-1];
        ld_d[k]  = ld_q[k-1];
        dst_d[k] = dst_q[k-1];
      end
      if (hz.flush_req || lu) begin
        v_d[1]   = 1'b0;
        wr_d[1]  = 1'b0;
        ld_d[1]  = 1'b0;
        dst_d[1] = '0;
      end else begin
        v_d[1]   = hz.id_valid;
        wr_d[1]  = hz.id_reg_write;
        ld_d[1]  = hz.id_mem_read;
        dst_d[1] = hz.id_dst;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q  <= '0;
      wr_q <= '0;
      ld_q <= '0;
      for (int k = 1; k <= N; k++)
        dst_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      wr_q  <= wr_d;
      ld_q  <= ld_d;
      dst_q <= dst_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (hz.flush_fd && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 16'h0000;
  assign hz.flush_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Testbench for pipeline_hazard_unit: directed scenarios plus randomized
// traffic against a queue-based reference model of the tracked writers.
module tb_pipeline_hazard_unit;
  localparam int NS = 3;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [2:0] dst;
    logic       wr;
    logic       ld;
  } ent_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  // m[0] is the instruction in EX (stage 1), m[i] is stage i+1.
  ent_t        m[$];
  int unsigned e_scnt;
  int unsigned e_fcnt;

  pipeline_hazard_unit_if #(.REG_ADDR_W(3), .NUM_STAGES(NS)) hz();

  pipeline_hazard_unit #(.REG_ADDR_W(3), .NUM_STAGES(NS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mfwd(input logic [2:0] src, input logic used);
    if (!hz.id_valid || !used) return 0;
    for (int i = 0; i < m.size(); i++)
      if (m[i].v && m[i].wr && m[i].dst == src) return i + 1;
    return 0;
  endfunction

  function automatic bit mlu();
    if (!hz.id_valid || !m[0].v || !m[0].ld || !m[0].wr) return 1'b0;
    return (hz.id_src1_used && m[0].dst == hz.id_src1) ||
           (hz.id_src2_used && m[0].dst == hz.id_src2);
  endfunction

  function automatic void mreset();
    m.delete();
    for (int i = 0; i < NS; i++) m.push_back('0);
    e_scnt = 0;
    e_fcnt = 0;
  endfunction

  task automatic drive(input bit v, input bit [2:0] s1, input bit [2:0] s2,
                       input bit u1, input bit u2, input bit [2:0] d,
                       input bit w, input bit l, input bit fl, input bit sx);
    hz.id_valid     = v;
    hz.id_src1      = s1;
    hz.id_src2      = s2;
    hz.id_src1_used = u1;
    hz.id_src2_used = u2;
    hz.id_dst       = d;
    hz.id_reg_write = w;
    hz.id_mem_read  = l;
    hz.flush_req    = fl;
    hz.stall_ext    = sx;
    #1;
  endtask

  // Advance one clock; the model takes the same edge using the held inputs.
  task automatic tick();
    ent_t e;
    bit   lu;
    @(posedge clk);
    lu = mlu();
    if (lu && e_scnt < 16'hFFFF) e_scnt++;
    if (hz.flush_req && !hz.stall_ext && e_fcnt < 16'hFFFF) e_fcnt++;
    if (!hz.stall_ext) begin
      if (hz.flush_req || lu) e = '0;
      else e = '{hz.id_valid, hz.id_dst, hz.id_reg_write, hz.id_mem_read};
      m.push_front(e);
      void'(m.pop_back());
    end
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    mreset();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    tests++;
    if ({hz.stall, hz.bubble, hz.flush_fd} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctl: got %b expected 000",
               {hz.stall, hz.bubble, hz.flush_fd});
    end
    tests++;
    if ({hz.fwd_sel1, hz.fwd_sel2} !== 4'h0) begin
      fails++;
      $display("FAIL reset_fwd: got %h expected 0", {hz.fwd_sel1, hz.fwd_sel2});
    end
    tests++;
    if ({hz.stall_cnt, hz.flush_cnt} !== 32'h0) begin
      fails++;
      $display("FAIL reset_cnt: got %h expected 0", {hz.stall_cnt, hz.flush_cnt});
    end
    apply_reset();
  endtask

  task automatic test_alu_chain();
    apply_reset();
    drive(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
    tick();
    drive(1, 3, 5, 1, 1, 4, 1, 0, 0, 0);
    tests++;
    if (hz.fwd_sel1 !== 2'd1 || hz.stall !== 1'b0) begin
      fails++;
      $display("FAIL alu_chain: got sel=%0d stall=%b expected sel=1 stall=0",
               hz.fwd_sel1, hz.stall);
    end
    tests++;
    if (hz.fwd_sel2 !== 2'd0) begin
      fails++;
      $display("FAIL alu_chain_op2: got %0d expected 0", hz.fwd_sel2);
    end
  endtask

  task automatic test_distance();
    apply_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    tick();
    drive(1, 3, 0, 1, 0, 7, 0, 0, 0, 0);
    tests++;
    if (hz.fwd_sel1 !== 2'd3) begin
      fails++;
      $display("FAIL distance3: got %0d expected 3", hz.fwd_sel1);
    end
    tick();
    drive(1, 3, 0, 1, 0, 7, 0, 0, 0, 0);
    tests++;
    if (hz.fwd_sel1 !== 2'd0) begin
      fails++;
      $display("FAIL distance_off: got %0d expected 0", hz.fwd_sel1);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(1, 2, 5, 1, 1, 4, 1, 0, 0, 0);
    tests++;
    if ({hz.stall, hz.bubble} !== 2'b11) begin
      fails++;
      $display("FAIL lu_stall: got %b expected 11", {hz.stall, hz.bubble});
    end
    tick();
    tests++;
    if ({hz.stall, hz.bubble} !== 2'b00 || hz.fwd_sel1 !== 2'd2) begin
      fails++;
      $display("FAIL lu_after: got st/bb=%b sel=%0d expected 00 sel=2",
               {hz.stall, hz.bubble}, hz.fwd_sel1);
    end
    // A non-valid decode slot never stalls even against a pending load.
    apply_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(0, 2, 2, 1, 1, 4, 1, 0, 0, 0);
    tests++;
    if ({hz.stall, hz.fwd_sel1} !== 3'b000) begin
      fails++;
      $display("FAIL invalid_id: got %b expected 000", {hz.stall, hz.fwd_sel1});
    end
  endtask

  task automatic test_nearest();
    apply_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
    tests++;
    if (hz.fwd_sel1 !== 2'd1 || hz.fwd_sel2 !== 2'd1) begin
      fails++;
      $display("FAIL nearest: got %0d/%0d expected 1/1", hz.fwd_sel1, hz.fwd_sel2);
    end
  endtask

  task automatic test_flush_lu();
    apply_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(1, 2, 0, 1, 0, 4, 1, 0, 1, 0);
    tests++;
    if ({hz.flush_fd, hz.bubble, hz.stall} !== 3'b101) begin
      fails++;
      $display("FAIL flush_lu: got fl/bb/st=%b expected 101",
               {hz.flush_fd, hz.bubble, hz.stall});
    end
    tick();
    drive(1, 2, 0, 1, 0, 4, 1, 0, 0, 0);
    tests++;
    if (hz.fwd_sel1 !== 2'd2 || hz.stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_e1: got sel=%0d stall=%b expected sel=2 stall=0",
               hz.fwd_sel1, hz.stall);
    end
  endtask

  task automatic test_stall_ext();
    apply_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    drive(1, 6, 7, 1, 1, 4, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (hz.fwd_sel1 !== 2'd2 || hz.fwd_sel2 !== 2'd1 ||
          {hz.stall, hz.bubble, hz.flush_fd} !== 3'b100) begin
        fails++;
        $display("FAIL stall_ext%0d: got %0d/%0d ctl=%b expected 2/1 ctl=100",
                 i, hz.fwd_sel1, hz.fwd_sel2, {hz.stall, hz.bubble, hz.flush_fd});
      end
      tick();
    end
    drive(1, 6, 7, 1, 1, 4, 0, 0, 0, 0);
    tests++;
    if (hz.fwd_sel1 !== 2'd2 || hz.fwd_sel2 !== 2'd1 || hz.stall !== 1'b0) begin
      fails++;
      $display("FAIL stall_rel: got %0d/%0d st=%b expected 2/1 st=0",
               hz.fwd_sel1, hz.fwd_sel2, hz.stall);
    end
    drive(1, 6, 7, 1, 1, 4, 0, 0, 1, 1);
    reset_n = 1'b0;
    #1;
    tests++;
    if ({hz.stall, hz.bubble, hz.flush_fd, hz.fwd_sel1, hz.fwd_sel2} !== 7'b0) begin
      fails++;
      $display("FAIL reset_mid: got %b expected 0",
               {hz.stall, hz.bubble, hz.flush_fd, hz.fwd_sel1, hz.fwd_sel2});
    end
    apply_reset();
  endtask

  task automatic test_random();
    int e1, e2;
    bit lu;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0);
      lu = mlu();
      e1 = mfwd(hz.id_src1, hz.id_src1_used);
      e2 = mfwd(hz.id_src2, hz.id_src2_used);
      tests++;
      if (hz.stall !== (lu || hz.stall_ext) ||
          hz.bubble !== (lu && !hz.stall_ext && !hz.flush_req) ||
          hz.flush_fd !== (hz.flush_req && !hz.stall_ext)) begin
        fails++;
        $display("FAIL rnd_ctl@%0d: got st/bb/fl=%b%b%b expected %b%b%b", n,
                 hz.stall, hz.bubble, hz.flush_fd, lu || hz.stall_ext,
                 lu && !hz.stall_ext && !hz.flush_req,
                 hz.flush_req && !hz.stall_ext);
      end
      tests++;
      if (int'(hz.fwd_sel1) != e1 || int'(hz.fwd_sel2) != e2 ||
          $isunknown({hz.fwd_sel1, hz.fwd_sel2})) begin
        fails++;
        $display("FAIL rnd_fwd@%0d: got %0d/%0d expected %0d/%0d", n,
                 hz.fwd_sel1, hz.fwd_sel2, e1, e2);
      end
      tests++;
      if (hz.stall_cnt !== (STATS ? 16'(e_scnt) : 16'h0) ||
          hz.flush_cnt !== (STATS ? 16'(e_fcnt) : 16'h0)) begin
        fails++;
        $display("FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", n,
                 hz.stall_cnt, hz.flush_cnt, STATS ? e_scnt : 0,
                 STATS ? e_fcnt : 0);
      end
      tick();
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats_sat();
    apply_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    // Frozen pipe keeps the load-use condition live every cycle.
    drive(1, 2, 0, 1, 0, 4, 1, 0, 0, 1);
    repeat (70000) @(posedge clk);
    #1;
    tests++;
    if (hz.stall_cnt !== 16'hFFFF || hz.flush_cnt !== 16'h0) begin
      fails++;
      $display("FAIL stats_sat: got %h/%h expected ffff/0000",
               hz.stall_cnt, hz.flush_cnt);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    mreset();
    test_reset();
    test_alu_chain();
    test_distance();
    test_load_use();
    test_nearest();
    test_flush_lu();
    test_stall_ext();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats_sat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
